// File: rtl/img_pkg.sv
// Shared image constants and pixel types for the camera / frame-buffer path.
// Helpers here define the per-channel arithmetic used by the 2x2 downscaler.
package img_pkg;

    localparam int unsigned IN_W   = 640;
    localparam int unsigned IN_H   = 480;
    localparam int unsigned OUT_W  = IN_W / 2;
    localparam int unsigned OUT_H  = IN_H / 2;
    localparam int unsigned DW     = 12;
    localparam int unsigned PAIR_W = 15;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Horizontal pair sum: one extra bit per channel so nothing is lost before averaging.
    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } pair_t;

    typedef enum logic [1:0] {StIdle, StActive, StDone} ds_state_e;

    function automatic logic [3:0] ch_r(rgb444_t p);
        return p.r;
    endfunction

    function automatic logic [3:0] ch_g(rgb444_t p);
        return p.g;
    endfunction

    function automatic logic [3:0] ch_b(rgb444_t p);
        return p.b;
    endfunction

    function automatic pair_t pair_add(rgb444_t a, rgb444_t b);
        pair_t s;
        s.r = {1'b0, ch_r(a)} + {1'b0, ch_r(b)};
        s.g = {1'b0, ch_g(a)} + {1'b0, ch_g(b)};
        s.b = {1'b0, ch_b(a)} + {1'b0, ch_b(b)};
        return s;
    endfunction

    // Sum of two pair words is the 4-pixel sum; dropping two LSBs truncates the mean.
    function automatic rgb444_t quad_avg(pair_t a, pair_t b);
        logic [5:0] sr;
        logic [5:0] sg;
        logic [5:0] sb;
        sr = {1'b0, a.r} + {1'b0, b.r};
        sg = {1'b0, a.g} + {1'b0, b.g};
        sb = {1'b0, a.b} + {1'b0, b.b};
        return {sr[5:2], sg[5:2], sb[5:2]};
    endfunction

endpackage

// File: rtl/pair_line_buffer.sv
// One-line store of horizontal pair sums from the even row, read back on the odd row.
// Read data is registered on rd_en and held until the next read.
module pair_line_buffer
    import img_pkg::*;
#(
    parameter int unsigned DEPTH = OUT_W,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pair_t         wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pair_t         rd_data
);

    pair_t mem [DEPTH];
    pair_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_downscaler_2x2.sv
// Averages each 2x2 block of the incoming RGB444 stream into one output pixel.
// Even rows store horizontal pair sums; odd rows combine them and emit a pixel.
module pixel_downscaler_2x2 #(
    parameter int unsigned IN_W = 640,
    parameter int unsigned IN_H = 480,
    parameter int unsigned DW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [DW-1:0] pixel_data,
    input  logic          pixel_valid,
    output logic [DW-1:0] scaled_data,
    output logic          scaled_valid,
    output logic          scaled_sof
);

    import img_pkg::*;

    localparam int unsigned XW     = $clog2(IN_W);
    localparam int unsigned YW     = $clog2(IN_H);
    localparam int unsigned AW     = XW - 1;
    localparam logic [XW-1:0] XLast = XW'(IN_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IN_H - 1);

    ds_state_e     state_q, state_d;
    logic [XW-1:0] x_q, x_d, cur_x;
    logic [YW-1:0] y_q, y_d, cur_y;
    rgb444_t       pix_q;
    rgb444_t       cur_pix;
    pair_t         pair_w;
    pair_t         rd_pair;
    logic          accept;
    logic          wr_en;
    logic          rd_en;
    logic          out_valid;
    logic          out_sof;

    // frame_start restarts the position counters in the same cycle it arrives.
    always_comb begin
        cur_x   = frame_start ? '0 : x_q;
        cur_y   = frame_start ? '0 : y_q;
        accept  = pixel_valid && (frame_start || (state_q == StActive));
        state_d = frame_start ? StActive : state_q;
        x_d     = cur_x;
        y_d     = cur_y;
        if (accept) begin
            if (cur_x == XLast) begin
                x_d = '0;
                if (cur_y == YLast) begin
                    y_d     = '0;
                    state_d = StDone;
                end else begin
                    y_d = cur_y + YW'(1);
                end
            end else begin
                x_d = cur_x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        cur_pix   = rgb444_t'(pixel_data);
        pair_w    = pair_add(pix_q, cur_pix);
        wr_en     = accept && cur_x[0] && !cur_y[0];
        rd_en     = accept && !cur_x[0] && cur_y[0];
        out_valid = accept && cur_x[0] && cur_y[0];
        out_sof   = out_valid && (cur_x == XW'(1)) && (cur_y == YW'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q <= '0;
        end else if (accept && !cur_x[0]) begin
            pix_q <= cur_pix;
        end
    end

    pair_line_buffer #(
        .DEPTH (IN_W / 2),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (cur_x[XW-1:1]),
        .wr_data (pair_w),
        .rd_en   (rd_en),
        .rd_addr (cur_x[XW-1:1]),
        .rd_data (rd_pair)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scaled_data  <= '0;
            scaled_valid <= 1'b0;
            scaled_sof   <= 1'b0;
        end else begin
            scaled_valid <= out_valid;
            scaled_sof   <= out_sof;
            if (out_valid) begin
                scaled_data <= quad_avg(rd_pair, pair_w);
            end
        end
    end

endmodule

// File: tb/tb_pixel_downscaler_2x2.sv
// Randomized scoreboard bench for pixel_downscaler_2x2 on a reduced 16x8 frame.
module tb_pixel_downscaler_2x2;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int OW = W / 2;
    localparam int OH = H / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [11:0] pixel_data;
    logic        pixel_valid;
    logic [11:0] scaled_data;
    logic        scaled_valid;
    logic        scaled_sof;

    pixel_downscaler_2x2 #(
        .IN_W (W),
        .IN_H (H),
        .DW   (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .scaled_data  (scaled_data),
        .scaled_valid (scaled_valid),
        .scaled_sof   (scaled_sof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] data;
        logic        sof;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    bit          prev_v = 1'b0;
    logic [11:0] img [H][W];
    logic [11:0] pat [H][W];
    bit          m_active = 1'b0;
    int          m_n = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] avg4(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c, input logic [11:0] d);
        logic [11:0] r;
        int          s;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(a[ch*4+:4]) + int'(b[ch*4+:4]) + int'(c[ch*4+:4]) + int'(d[ch*4+:4]);
            r[ch*4+:4] = 4'(s / 4);
        end
        return r;
    endfunction

    // Reference: a frame is W*H accepted pixels in raster order after frame_start.
    task automatic model_pixel(input bit fs, input logic [11:0] d);
        int   x;
        int   y;
        exp_t e;
        if (fs) begin
            m_active = 1'b1;
            m_n      = 0;
        end
        if (!m_active) return;
        x = m_n % W;
        y = m_n / W;
        img[y][x] = d;
        if ((x % 2 == 1) && (y % 2 == 1)) begin
            e.data = avg4(img[y-1][x-1], img[y-1][x], img[y][x-1], img[y][x]);
            e.sof  = (x == 1) && (y == 1);
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        m_n++;
        if (m_n == W * H) m_active = 1'b0;
    endtask

    task automatic fill_pat(input int mode);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                pat[y][x] = (mode == 0) ? 12'hABC : 12'($urandom);
            end
        end
        if (mode == 2) begin
            pat[0][0] = 12'h000; pat[0][1] = 12'h111;
            pat[1][0] = 12'h222; pat[1][1] = 12'h333;
            pat[0][2] = 12'hFFF; pat[0][3] = 12'hFFF;
            pat[1][2] = 12'hFFF; pat[1][3] = 12'hFFE;
        end
    endtask

    task automatic drive(input int npix, input int maxgap, input bit start, input bit sep);
        if (start && sep) begin
            @(posedge clk); #1;
            frame_start = 1'b1;
            pixel_valid = 1'b0;
            m_active    = 1'b1;
            m_n         = 0;
        end
        for (int n = 0; n < npix; n++) begin
            int gap;
            gap = int'($urandom_range(maxgap, 0));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                frame_start = 1'b0;
                pixel_valid = 1'b0;
                pixel_data  = 12'($urandom);
            end
            @(posedge clk); #1;
            frame_start = start && !sep && (n == 0);
            pixel_valid = 1'b1;
            pixel_data  = pat[(n / W) % H][n % W];
            model_pixel(frame_start, pixel_data);
        end
        @(posedge clk); #1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic expect_count(input string name, input int n);
        repeat (3) @(posedge clk);
        #1;
        check(name, out_cnt, n);
        check({name, "_drained"}, q.size(), 0);
        out_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (scaled_valid) begin
                check("no_back_to_back", prev_v, 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got scaled_valid=1 data %0h, required none",
                             scaled_data);
                end else begin
                    mon_e = q.pop_front();
                    check("scaled_data", scaled_data, mon_e.data);
                    check("scaled_sof", scaled_sof, mon_e.sof);
                    check("latency_cycle", cyc, mon_e.cyc);
                end
                out_cnt++;
            end
            prev_v = scaled_valid;
        end
    end

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        #1;
        check("reset_data", scaled_data, 0);
        check("reset_valid", scaled_valid, 0);
        check("reset_sof", scaled_sof, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        fill_pat(1);
        drive(W, 0, 1'b0, 1'b0);
        expect_count("idle_ignored", 0);

        fill_pat(0);
        drive(W * H, 0, 1'b1, 1'b0);
        expect_count("uniform_frame", OW * OH);

        fill_pat(2);
        drive(W * H, 0, 1'b1, 1'b1);
        expect_count("directed_frame", OW * OH);

        fill_pat(1);
        drive(W * H, 3, 1'b1, 1'b0);
        expect_count("gapped_frame", OW * OH);

        drive(2 * W, 0, 1'b0, 1'b0);
        expect_count("done_ignored", 0);

        fill_pat(1);
        drive(5 * W, 1, 1'b1, 1'b0);
        fill_pat(2);
        drive(W * H, 2, 1'b1, 1'b0);
        expect_count("restart_frames", 2 * OW + OW * OH);

        // Last pixel is (1,5): its output is registered and then killed by reset.
        fill_pat(1);
        drive(5 * W + 2, 0, 1'b1, 1'b0);
        check("pre_reset_valid", scaled_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("midreset_data", scaled_data, 0);
        check("midreset_valid", scaled_valid, 0);
        check("midreset_sof", scaled_sof, 0);
        q.delete();
        m_active = 1'b0;
        check("midreset_outputs", out_cnt, 2 * OW);
        out_cnt = 0;
        @(posedge clk); #1 rst = 1'b1;

        drive(2 * W, 0, 1'b0, 1'b0);
        expect_count("post_reset_ignored", 0);

        fill_pat(1);
        drive(W * H, 2, 1'b1, 1'b0);
        expect_count("post_reset_frame", OW * OH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
